// File: rtl/pipe_sub_pkg.sv
// Shared definitions for the pipelined subtractor: operation encodings and
// the width/ceiling of the clamp counter.
package pipe_sub_pkg;

  typedef enum logic [1:0] {
    MODE_DIFF = 2'b00,
    MODE_ABS  = 2'b01,
    MODE_SAT  = 2'b10,
    MODE_REV  = 2'b11
  } mode_e;

  localparam int SAT_CNT_W = 16;
  localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = '1;

endpackage

// File: rtl/pipe_sub_alu.sv
// Combinational core of pipe_sub: W+1-bit difference, then the mode-specific
// post-processing (absolute value, clamp, reversed operands).
module pipe_sub_alu
  import pipe_sub_pkg::*;
#(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   mode,
  output logic [W:0]   c,
  output logic         neg,
  output logic         clamped
);

  logic [W:0] ext_a;
  logic [W:0] ext_b;
  logic [W:0] d;
  logic [W:0] d_rev;
  logic [W:0] sat_max;
  logic [W:0] sat_min;

  // One extra bit holds any difference of two W-bit operands without overflow.
  assign ext_a   = SIGNED ? {a[W-1], a} : {1'b0, a};
  assign ext_b   = SIGNED ? {b[W-1], b} : {1'b0, b};
  assign d       = ext_a - ext_b;
  assign d_rev   = ext_b - ext_a;
  assign neg     = d[W];
  assign sat_max = {2'b00, {(W-1){1'b1}}};
  assign sat_min = {2'b11, {(W-1){1'b0}}};

  always_comb begin
    c       = d;
    clamped = 1'b0;
    unique case (mode_e'(mode))
      MODE_DIFF: c = d;
      MODE_ABS:  c = neg ? d_rev : d;
      MODE_SAT: begin
        if (!SIGNED) begin
          if (neg) begin
            c       = '0;
            clamped = 1'b1;
          end
        end else if ($signed(d) > $signed(sat_max)) begin
          c       = sat_max;
          clamped = 1'b1;
        end else if ($signed(d) < $signed(sat_min)) begin
          c       = sat_min;
          clamped = 1'b1;
        end
      end
      MODE_REV:  c = d_rev;
    endcase
  end

endmodule

// File: rtl/pipe_sub.sv
// Two-stage valid/ready subtractor pipeline: S1 holds operands, S2 holds the
// result; also counts clamped results as they leave.
module pipe_sub
  import pipe_sub_pkg::*;
#(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W:0]           c,
  output logic                 neg,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds valid and payload until that edge, and ready
  // may depend combinationally on the consumer's ready.

  logic           s1_valid;
  logic [W-1:0]   s1_a;
  logic [W-1:0]   s1_b;
  logic [1:0]     s1_mode;
  logic           s2_clamped;
  logic [W:0]     alu_c;
  logic           alu_neg;
  logic           alu_clamped;
  logic           s2_advance;
  logic           s1_open;
  logic           out_xfer;

  assign s2_advance = !out_valid || out_ready;
  assign s1_open    = !s1_valid || s2_advance;
  assign in_ready   = !rst && s1_open;
  assign out_xfer   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '0;
    end else if (s1_open) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_mode <= mode;
      end
    end
  end

  pipe_sub_alu #(
    .W      (W),
    .SIGNED (SIGNED)
  ) u_alu (
    .a       (s1_a),
    .b       (s1_b),
    .mode    (s1_mode),
    .c       (alu_c),
    .neg     (alu_neg),
    .clamped (alu_clamped)
  );

  // S2 only reloads when it can hand its content on, so a stalled result
  // stays frozen on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      c          <= '0;
      neg        <= 1'b0;
      s2_clamped <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        c          <= alu_c;
        neg        <= alu_neg;
        s2_clamped <= alu_clamped;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (out_xfer && s2_clamped && (sat_cnt != SAT_CNT_MAX)) begin
      sat_cnt <= sat_cnt + SAT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_sub.sv
// Bench for pipe_sub: an unsigned and a signed instance share stimulus; a
// per-instance expected queue built from arithmetic rules checks every output.
module tb_pipe_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  mode;

  logic        rdy_u, ov_u, neg_u;
  logic [8:0]  c_u;
  logic [15:0] sc_u;
  logic        rdy_s, ov_s, neg_s;
  logic [8:0]  c_s;
  logic [15:0] sc_s;

  // {clamped, neg, c[8:0]}
  logic [10:0] exp_q_u[$];
  logic [10:0] exp_q_s[$];
  int          exp_sat_u;
  int          exp_sat_s;
  int          checks;
  int          errors;
  bit          rand_or;

  always #5 clk = ~clk;

  pipe_sub #(.W(8), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_u),
    .a(a), .b(b), .mode(mode), .out_valid(ov_u), .out_ready(out_ready),
    .c(c_u), .neg(neg_u), .sat_cnt(sc_u)
  );

  pipe_sub #(.W(8), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s),
    .a(a), .b(b), .mode(mode), .out_valid(ov_s), .out_ready(out_ready),
    .c(c_s), .neg(neg_s), .sat_cnt(sc_s)
  );

  function automatic logic [10:0] model(input logic [7:0] ai, input logic [7:0] bi,
                                        input logic [1:0] m, input bit sgn);
    int av, bv, d, r;
    bit cl;
    av = sgn ? int'($signed(ai)) : int'(ai);
    bv = sgn ? int'($signed(bi)) : int'(bi);
    d  = av - bv;
    r  = d;
    cl = 1'b0;
    case (m)
      2'd0: r = d;
      2'd1: r = (d < 0) ? -d : d;
      2'd2: begin
        if (!sgn) r = (d < 0) ? 0 : d;
        else      r = (d > 127) ? 127 : ((d < -128) ? -128 : d);
        cl = (r != d);
      end
      default: r = bv - av;
    endcase
    return {cl, (d < 0), r[8:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Scoreboard: compare the front of each expected queue whenever a result is shown.
  always @(negedge clk) begin
    if (rst) begin
      check("rdy_in_rst", {31'd0, rdy_u}, 32'd0);
      exp_q_u.delete();
      exp_q_s.delete();
      exp_sat_u = 0;
      exp_sat_s = 0;
    end else begin
      check("sat_cnt_u", {16'd0, sc_u}, exp_sat_u);
      if (ov_u) begin
        if (exp_q_u.size() == 0) check("stray_out_u", {31'd0, ov_u}, 32'd0);
        else begin
          check("c_u", {23'd0, c_u}, {23'd0, exp_q_u[0][8:0]});
          check("neg_u", {31'd0, neg_u}, {31'd0, exp_q_u[0][9]});
          if (out_ready) begin
            if (exp_q_u[0][10] && exp_sat_u < 65535) exp_sat_u++;
            void'(exp_q_u.pop_front());
          end
        end
      end
      check("sat_cnt_s", {16'd0, sc_s}, exp_sat_s);
      if (ov_s) begin
        if (exp_q_s.size() == 0) check("stray_out_s", {31'd0, ov_s}, 32'd0);
        else begin
          check("c_s", {23'd0, c_s}, {23'd0, exp_q_s[0][8:0]});
          check("neg_s", {31'd0, neg_s}, {31'd0, exp_q_s[0][9]});
          if (out_ready) begin
            if (exp_q_s[0][10] && exp_sat_s < 65535) exp_sat_s++;
            void'(exp_q_s.pop_front());
          end
        end
      end
      if (in_valid && rdy_u) exp_q_u.push_back(model(a, b, mode, 1'b0));
      if (in_valid && rdy_s) exp_q_s.push_back(model(a, b, mode, 1'b1));
    end
  end

  task automatic send(input logic [7:0] ai, input logic [7:0] bi, input logic [1:0] mi);
    int  n;
    bit  took;
    a = ai; b = bi; mode = mi; in_valid = 1'b1;
    n = 0;
    took = 1'b0;
    do begin
      @(negedge clk);
      took = rdy_u;
      tick();
      n++;
    end while (!took && n < 200);
    check("send_timeout", {31'd0, took}, 32'd1);
    in_valid = 1'b0;
  endtask

  // Single transfer with out_ready high: result must show exactly two cycles later.
  task automatic pin(input string nm, input logic [7:0] ai, input logic [7:0] bi,
                     input logic [1:0] mi, input bit sel_s, input logic [8:0] ec,
                     input bit en);
    send(ai, bi, mi);
    @(negedge clk);
    check({nm, "_early"}, {31'd0, sel_s ? ov_s : ov_u}, 32'd0);
    tick();
    @(negedge clk);
    check({nm, "_valid"}, {31'd0, sel_s ? ov_s : ov_u}, 32'd1);
    check({nm, "_c"}, {23'd0, sel_s ? c_s : c_u}, {23'd0, ec});
    check({nm, "_neg"}, {31'd0, sel_s ? neg_s : neg_u}, {31'd0, en});
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q_u.size() != 0 || exp_q_s.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check("drain", exp_q_u.size() + exp_q_s.size(), 32'd0);
  endtask

  logic [7:0] pa[5];
  logic [7:0] pb[5];

  initial begin
    int  idx, acc;
    bit  took;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = '0;
    out_ready = 1'b1; rand_or = 1'b0;
    checks = 0; errors = 0; exp_sat_u = 0; exp_sat_s = 0;

    tick();
    @(negedge clk);
    check("rst_out_valid", {31'd0, ov_u}, 32'd0);
    check("rst_c", {23'd0, c_u}, 32'd0);
    check("rst_neg", {31'd0, neg_u}, 32'd0);
    check("rst_sat_cnt", {16'd0, sc_u}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", {31'd0, rdy_u}, 32'd1);
    tick();

    // Unsigned literal points.
    pin("diff_neg", 8'd10, 8'd20, 2'b00, 1'b0, 9'h1F6, 1'b1);
    pin("diff_zero", 8'd20, 8'd20, 2'b00, 1'b0, 9'h000, 1'b0);
    pin("abs", 8'd10, 8'd20, 2'b01, 1'b0, 9'd10, 1'b1);
    pin("sat_u", 8'd10, 8'd20, 2'b10, 1'b0, 9'd0, 1'b1);
    @(negedge clk);
    check("sat_cnt_one", {16'd0, sc_u}, 32'd1);
    tick();
    pin("rev", 8'd10, 8'd20, 2'b11, 1'b0, 9'd10, 1'b1);

    // Signed literal points.
    pin("s_diff", 8'h80, 8'h01, 2'b00, 1'b1, 9'h17F, 1'b1);
    pin("s_sat_lo", 8'h80, 8'h01, 2'b10, 1'b1, 9'h180, 1'b1);
    @(negedge clk);
    check("s_sat_cnt_one", {16'd0, sc_s}, 32'd1);
    tick();
    pin("s_sat_hi", 8'h7F, 8'hFF, 2'b10, 1'b1, 9'd127, 1'b0);
    @(negedge clk);
    check("s_sat_cnt_two", {16'd0, sc_s}, 32'd2);
    tick();

    // Backpressure: five pairs offered while out_ready is low for six cycles.
    for (int i = 0; i < 5; i++) begin
      pa[i] = 8'($urandom_range(0, 255));
      pb[i] = 8'($urandom_range(0, 255));
    end
    out_ready = 1'b0;
    idx = 0; acc = 0;
    a = pa[0]; b = pb[0]; mode = 2'b00; in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      took = in_valid && rdy_u;
      if (took) acc++;
      tick();
      if (took) begin
        idx++;
        if (idx < 5) begin a = pa[idx]; b = pb[idx]; end
        else in_valid = 1'b0;
      end
    end
    check("stall_accepts", acc, 32'd2);
    @(negedge clk);
    check("stall_rdy", {31'd0, rdy_u}, 32'd0);
    tick();
    out_ready = 1'b1;
    while (idx < 5) begin
      send(pa[idx], pb[idx], 2'b00);
      idx++;
    end
    drain();

    // Reset with two clamped results held in the pipe.
    out_ready = 1'b0;
    send(8'd0, 8'd5, 2'b10);
    send(8'd1, 8'd9, 2'b10);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", {31'd0, ov_u}, 32'd0);
    check("mid_rst_sat_u", {16'd0, sc_u}, 32'd0);
    check("mid_rst_sat_s", {16'd0, sc_s}, 32'd0);
    check("mid_rst_rdy", {31'd0, rdy_u}, 32'd1);
    tick();
    pin("post_rst", 8'd3, 8'd1, 2'b00, 1'b0, 9'd2, 1'b0);

    // Randomized traffic with random backpressure.
    rand_or = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_or = 1'b0;
    out_ready = 1'b1;
    drain();

    // Counter ceiling: stream clamped results past 65535.
    a = 8'd0; b = 8'd1; mode = 2'b10; in_valid = 1'b1;
    repeat (65540) tick();
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("sat_hold", {16'd0, sc_u}, 32'h0000FFFF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_sub.md
PIPE_SUB -- requirements
Module: pipe_sub

Interface
REQ-001 Parameter W, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter SIGNED, default 0; 0 treats operands as unsigned, 1 treats them as two's complement.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  an operand pair is presented.
REQ-006 in_ready  out  1  the block accepts an operand pair this cycle.
REQ-007 a  in  W  minuend.
REQ-008 b  in  W  subtrahend.
REQ-009 mode  in  2  operation select, sampled with a and b.
REQ-010 out_valid  out  1  a result is presented.
REQ-011 out_ready  in  1  downstream consumes the result this cycle.
REQ-012 c  out  W+1  result, two's complement unless stated otherwise.
REQ-013 neg  out  1  the raw difference a-b is negative.
REQ-014 sat_cnt  out  16  count of clamped results.

Function
REQ-015 An input transfer occurs when in_valid and in_ready are both high; an output transfer occurs when out_valid and out_ready are both high.
REQ-016 The datapath SHALL be a 2-stage pipeline: S1 registers a, b and mode; S2 registers c and neg.
REQ-017 With out_ready held high, the result SHALL appear on out_valid exactly 2 cycles after the input transfer, at a throughput of 1 per cycle.
REQ-018 Each stage SHALL advance when it is empty or when its successor advances; in_ready = !S1_valid || S1_advance (combinational from out_ready, no skid buffer).
REQ-019 Under backpressure, no result is dropped or duplicated and results leave in input order; at most 2 results are held.
REQ-020 c, neg and out_valid SHALL be stable while out_valid && !out_ready.
REQ-021 Raw difference d = a - b, computed in W+1 bits; operands are zero-extended if SIGNED=0 and sign-extended if SIGNED=1.
REQ-022 mode 00: c = d.
REQ-023 mode 01: c = |d|, as W+1-bit unsigned.
REQ-024 mode 10, SIGNED=0: c = 0 when d<0, else d.
REQ-025 mode 10, SIGNED=1: c = d clamped to [-2^(W-1), 2^(W-1)-1].
REQ-026 mode 11: c = b - a, with the same width rules as mode 00.
REQ-027 neg SHALL reflect the sign of a-b in every mode.
REQ-028 A result is "clamped" only in mode 10, and only when the clamp changed the value.
REQ-029 sat_cnt increments by 1 on the output transfer of each clamped result and saturates at 16'hFFFF.

Reset
REQ-030 While rst is high at a clock edge: S1_valid=0, out_valid=0, c=0, neg=0, sat_cnt=0; in-flight data is discarded.
REQ-031 in_ready SHALL be 0 while rst is high, and 1 in the first cycle after rst falls.
REQ-032 Reset applied mid-transfer SHALL take priority over any handshake in that cycle.

Structure
REQ-033 Package pipe_sub_pkg SHALL hold the mode encodings (MODE_DIFF=00, MODE_ABS=01, MODE_SAT=10, MODE_REV=11) and the sat_cnt width constant.
REQ-034 The arithmetic SHALL live in one combinational sub-module, pipe_sub_alu (inputs a, b, mode; outputs c, neg, clamped; parameters W and SIGNED); pipe_sub holds the pipeline registers, handshake logic and counter.

Verification
REQ-035 W=8, SIGNED=0, mode 00, a=10, b=20 -> 2 cycles later c=9'h1F6, neg=1; then a=20, b=20 -> c=0, neg=0.
REQ-036 W=8, SIGNED=0, a=10, b=20 -> mode 01 gives c=10; mode 10 gives c=0 and sat_cnt=1; mode 11 gives c=10, neg=1.
REQ-037 W=8, SIGNED=1, a=-128, b=1 -> mode 00 gives c=9'h17F (-129); mode 10 gives c=9'h180 (-128) and sat_cnt increments; a=127, b=-1 in mode 10 gives c=127.
REQ-038 Stream 5 pairs with out_ready low for 6 cycles -> in_ready falls after 2 accepts; all 5 results leave in order after out_ready rises; c stays stable while stalled.
REQ-039 Assert rst for 1 cycle with 2 results in flight -> out_valid=0 and sat_cnt=0 the next cycle, no stale result emerges, and a new pair completes with 2-cycle latency.
REQ-040 Force 65536 clamped results (or preload sat_cnt via hierarchy) -> sat_cnt holds at 16'hFFFF and does not wrap.
